// File: rtl/seq_pkg.sv
// Shared definitions for the serial pattern generator and the 1011 detector side.
package seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2,
        ST_DONE  = 2'd3
    } seq_state_e;

    localparam logic [3:0] SEQ_DEFAULT_PAT = 4'b1011;

    // Counter width that can hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/seq_piso_shreg.sv
// Parallel-in, serial-out shift register. Load wins over shift; exposes the MSB
// of the value being written so the owner can register it alongside its own state.
module seq_piso_shreg #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         load_i,
    input  logic         shift_i,
    input  logic [W-1:0] data_i,
    output logic         next_msb_o
);

    logic [W-1:0] sh_q;
    logic [W-1:0] sh_d;

    // NOTE: hold is assigned first so every path through the block drives sh_d and no latch is inferred.
    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = data_i;
        end else if (shift_i) begin
            sh_d = sh_q << 1;
        end
    end

    // NOTE: non-blocking assignment so every flop samples pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign next_msb_o = sh_d[W-1];

endmodule

// File: rtl/seq_gen_serial.sv
// Serial pattern transmitter: sends a latched pattern MSB-first for rep_in+1 bursts
// separated by GAP idle cycles, with a valid/ready load port and synchronous abort.
module seq_gen_serial
    import seq_pkg::*;
#(
    parameter int PAT_W = $bits(SEQ_DEFAULT_PAT),
    parameter int CNT_W = 4,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [CNT_W-1:0] rep_in,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             abort,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             busy,
    output logic             done
);

    localparam int BIT_W = cnt_width(PAT_W);
    localparam int GAP_W = cnt_width(GAP);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

    seq_state_e       state_q;
    logic [PAT_W-1:0] pat_q;
    logic [CNT_W-1:0] rep_q;
    logic [BIT_W-1:0] bit_q;
    logic [GAP_W-1:0] gap_q;
    logic             ser_bit_q;
    logic             ser_valid_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic             bit_last;
    logic             gap_last;
    logic             shifting;
    logic             sh_load;
    logic             sh_shift;
    logic [PAT_W-1:0] sh_data;
    logic             sh_next_msb;

    assign load_ready = (state_q == ST_IDLE) && !abort;
    assign accept     = load_valid && load_ready;
    assign bit_last   = (bit_q == BIT_LAST);
    assign gap_last   = (gap_q == GAP_LAST);
    assign shifting   = (state_q == ST_SHIFT) && !abort;

    // Reload at a burst end that has more bursts to go, so the next burst (after
    // the gap, or immediately when GAP==0) starts from the latched pattern.
    assign sh_load  = accept || (shifting && bit_last && (rep_q != '0));
    assign sh_shift = shifting;
    assign sh_data  = accept ? pat_in : pat_q;

    seq_piso_shreg #(
        .W(PAT_W)
    ) u_shreg (
        .clk       (clk),
        .reset_n   (reset_n),
        .load_i    (sh_load),
        .shift_i   (sh_shift),
        .data_i    (sh_data),
        .next_msb_o(sh_next_msb)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pat_q       <= '0;
            rep_q       <= '0;
            bit_q       <= '0;
            gap_q       <= '0;
            ser_bit_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else if (abort && (state_q != ST_IDLE)) begin
            state_q     <= ST_IDLE;
            rep_q       <= '0;
            bit_q       <= '0;
            gap_q       <= '0;
            ser_bit_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_SHIFT;
                        pat_q       <= pat_in;
                        rep_q       <= rep_in;
                        bit_q       <= '0;
                        ser_valid_q <= 1'b1;
                        ser_bit_q   <= sh_next_msb;
                        busy_q      <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (!bit_last) begin
                        bit_q     <= bit_q + BIT_W'(1);
                        ser_bit_q <= sh_next_msb;
                    end else begin
                        bit_q <= '0;
                        if (rep_q == '0) begin
                            state_q     <= ST_DONE;
                            ser_valid_q <= 1'b0;
                            ser_bit_q   <= 1'b0;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                        end else if (GAP > 0) begin
                            state_q     <= ST_GAP;
                            rep_q       <= rep_q - CNT_W'(1);
                            gap_q       <= '0;
                            ser_valid_q <= 1'b0;
                            ser_bit_q   <= 1'b0;
                        end else begin
                            rep_q     <= rep_q - CNT_W'(1);
                            ser_bit_q <= sh_next_msb;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_last) begin
                        state_q     <= ST_SHIFT;
                        ser_valid_q <= 1'b1;
                        ser_bit_q   <= sh_next_msb;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ser_bit   = ser_bit_q;
    assign ser_valid = ser_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_seq_gen_serial.sv
// Bench for seq_gen_serial: two instances (GAP=2 and GAP=0) against a per-cycle
// arithmetic model of the output stream, plus literal waveforms for key scenarios.
module tb_seq_gen_serial;

    localparam int PW = 4;
    localparam int CW = 4;

    logic          clk        = 1'b0;
    logic          reset_n    = 1'b1;
    logic [PW-1:0] pat_in     = '0;
    logic [CW-1:0] rep_in     = '0;
    logic          load_valid = 1'b0;
    logic          abort      = 1'b0;
    logic [1:0]    load_ready;
    logic [1:0]    ser_bit;
    logic [1:0]    ser_valid;
    logic [1:0]    busy;
    logic [1:0]    done;

    int n_compared = 0;
    int n_mismatch = 0;

    always #5 clk = ~clk;

    seq_gen_serial #(.PAT_W(PW), .CNT_W(CW), .GAP(2)) u_gap2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .pat_in    (pat_in),
        .rep_in    (rep_in),
        .load_valid(load_valid),
        .load_ready(load_ready[0]),
        .abort     (abort),
        .ser_bit   (ser_bit[0]),
        .ser_valid (ser_valid[0]),
        .busy      (busy[0]),
        .done      (done[0])
    );

    seq_gen_serial #(.PAT_W(PW), .CNT_W(CW), .GAP(0)) u_gap0 (
        .clk       (clk),
        .reset_n   (reset_n),
        .pat_in    (pat_in),
        .rep_in    (rep_in),
        .load_valid(load_valid),
        .load_ready(load_ready[1]),
        .abort     (abort),
        .ser_bit   (ser_bit[1]),
        .ser_valid (ser_valid[1]),
        .busy      (busy[1]),
        .done      (done[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: once a request is taken, position pos counts cycles from the first bit.
    // The transmission is (rep+1) bursts of PW bits with gap idle cycles between
    // them, followed by one done cycle.
    bit            m_act [2];
    int            m_pos [2];
    int            m_rep [2];
    logic [PW-1:0] m_pat [2];

    function automatic int gap_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    function automatic int span_of(input int i);
        return (m_rep[i] + 1) * PW + m_rep[i] * gap_of(i);
    endfunction

    // Returns {ser_valid, ser_bit, busy, done}.
    function automatic logic [3:0] model_out(input int i);
        int p;
        if (!m_act[i]) return 4'b0000;
        if (m_pos[i] == span_of(i)) return 4'b0001;
        p = m_pos[i] % (PW + gap_of(i));
        if (p < PW) return {1'b1, m_pat[i][PW-1-p], 1'b1, 1'b0};
        return 4'b0010;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                m_act[i] <= 1'b0;
            end else if (m_act[i]) begin
                if (abort || (m_pos[i] == span_of(i))) m_act[i] <= 1'b0;
                else m_pos[i] <= m_pos[i] + 1;
            end else if (load_valid && !abort) begin
                m_act[i] <= 1'b1;
                m_pos[i] <= 0;
                m_pat[i] <= pat_in;
                m_rep[i] <= int'(rep_in);
            end
        end
    end

    logic [3:0] exp_o;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!reset_n) begin
                check($sformatf("u%0d.rst_outs", i),
                      32'({ser_valid[i], ser_bit[i], busy[i], done[i]}), 32'd0);
            end else begin
                exp_o = model_out(i);
                check($sformatf("u%0d.ser_valid", i), 32'(ser_valid[i]), 32'(exp_o[3]));
                check($sformatf("u%0d.ser_bit", i), 32'(ser_bit[i]), 32'(exp_o[2]));
                check($sformatf("u%0d.busy", i), 32'(busy[i]), 32'(exp_o[1]));
                check($sformatf("u%0d.done", i), 32'(done[i]), 32'(exp_o[0]));
                check($sformatf("u%0d.load_ready", i), 32'(load_ready[i]),
                      32'(!m_act[i] && !abort));
            end
        end
    end

    logic [31:0] cap_v [2];
    logic [31:0] cap_b [2];
    logic [31:0] cap_d [2];
    logic [31:0] cap_r [2];

    // Records n consecutive cycles, earliest cycle in the most significant position.
    task automatic capture(input int n);
        for (int i = 0; i < 2; i++) begin
            cap_v[i] = '0; cap_b[i] = '0; cap_d[i] = '0; cap_r[i] = '0;
        end
        repeat (n) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                cap_v[i] = {cap_v[i][30:0], ser_valid[i]};
                cap_b[i] = {cap_b[i][30:0], ser_bit[i]};
                cap_d[i] = {cap_d[i][30:0], done[i]};
                cap_r[i] = {cap_r[i][30:0], load_ready[i]};
            end
        end
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        load_valid = 1'b0;
        abort      = 1'b0;
        while ((load_ready != 2'b11) && (k < 300)) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("idle_wait", 32'(k < 300), 32'd1);
    endtask

    // Returns one time unit into the first bit cycle (T+1) of the accepted request.
    task automatic do_load(input logic [PW-1:0] pat, input logic [CW-1:0] rep);
        wait_idle();
        pat_in     = pat;
        rep_in     = rep;
        load_valid = 1'b1;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        pat_in     = PW'($urandom);
        rep_in     = CW'($urandom);
    endtask

    int cnt_v [2];
    int cnt_1 [2];
    int cnt_d [2];

    initial begin
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.outs", 32'({ser_valid, ser_bit, busy, done}), 32'd0);
        reset_n = 1'b1;
        #1;
        check("reset.ready", 32'(load_ready), 32'd3);

        // Single 1011 burst: bits at T+1..T+4, done at T+5, ready at T+6.
        do_load(4'b1011, 4'd0);
        capture(6);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t1.u%0d.valid", i), cap_v[i], 32'b111100);
            check($sformatf("t1.u%0d.bits", i), cap_b[i], 32'b101100);
            check($sformatf("t1.u%0d.done", i), cap_d[i], 32'b000010);
            check($sformatf("t1.u%0d.ready", i), cap_r[i], 32'b000001);
        end

        // Three bursts: GAP=2 instance has two-cycle gaps, GAP=0 runs back to back.
        do_load(4'b1011, 4'd2);
        capture(17);
        check("t3.u0.valid", cap_v[0], 32'b11110011110011110);
        check("t3.u0.bits", cap_b[0], 32'b10110010110010110);
        check("t3.u0.done", cap_d[0], 32'b00000000000000001);
        check("t3.u1.valid", cap_v[1], 32'b11111111111100000);
        check("t3.u1.bits", cap_b[1], 32'b10111011101100000);
        check("t3.u1.done", cap_d[1], 32'b00000000000010000);

        // Load request held during a burst is neither accepted nor disturbs the data.
        do_load(4'b1011, 4'd0);
        load_valid = 1'b1;
        pat_in     = 4'b0000;
        capture(5);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t4.u%0d.valid", i), cap_v[i], 32'b11110);
            check($sformatf("t4.u%0d.bits", i), cap_b[i], 32'b10110);
            check($sformatf("t4.u%0d.ready", i), cap_r[i], 32'b00000);
        end
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        capture(4);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t4.u%0d.no_second", i), cap_v[i], 32'b0000);
        end

        // Abort on the second bit, then a new load right after abort drops.
        do_load(4'b1011, 4'd3);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        check("t5.ready_during_abort", 32'(load_ready), 32'd0);
        @(posedge clk);
        #1;
        abort      = 1'b0;
        load_valid = 1'b1;
        pat_in     = 4'b1011;
        rep_in     = 4'd0;
        @(negedge clk);
        check("t5.after_abort", 32'({ser_valid, busy, done}), 32'd0);
        check("t5.ready_after", 32'(load_ready), 32'd3);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        @(negedge clk);
        check("t5.reload_first_bit", 32'({ser_valid, ser_bit}), 32'b1111);

        // Abort in IDLE blocks an accept in the same cycle.
        wait_idle();
        abort      = 1'b1;
        load_valid = 1'b1;
        @(negedge clk);
        check("t5.idle_abort_ready", 32'(load_ready), 32'd0);
        @(posedge clk);
        #1;
        abort      = 1'b0;
        load_valid = 1'b0;
        @(negedge clk);
        check("t5.idle_abort_no_start", 32'({busy, ser_valid}), 32'd0);

        // Asynchronous reset in the middle of a long transmission.
        do_load(4'b1011, 4'd5);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("t6.async_outs", 32'({ser_valid, ser_bit, busy, done}), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
        check("t6.ready_release", 32'(load_ready), 32'd3);
        do_load(4'b1011, 4'd0);
        capture(6);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("t6.u%0d.bits", i), cap_b[i], 32'b101100);
            check($sformatf("t6.u%0d.done", i), cap_d[i], 32'b000010);
        end

        // All-ones repeat count gives 16 bursts.
        do_load(4'b1100, 4'hF);
        for (int i = 0; i < 2; i++) begin
            cnt_v[i] = 0; cnt_1[i] = 0; cnt_d[i] = 0;
        end
        repeat (100) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                cnt_v[i] += int'(ser_valid[i]);
                cnt_1[i] += int'(ser_valid[i] & ser_bit[i]);
                cnt_d[i] += int'(done[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            check($sformatf("maxrep.u%0d.valid_cycles", i), 32'(cnt_v[i]), 32'd64);
            check($sformatf("maxrep.u%0d.ones", i), 32'(cnt_1[i]), 32'd32);
            check($sformatf("maxrep.u%0d.done_pulses", i), 32'(cnt_d[i]), 32'd1);
        end

        // Random traffic against the model.
        repeat (3000) begin
            @(posedge clk);
            #1;
            load_valid = ($urandom_range(0, 3) == 0);
            pat_in     = PW'($urandom);
            rep_in     = CW'($urandom);
            abort      = ($urandom_range(0, 99) == 0);
        end
        wait_idle();
        repeat (2) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
